imem_loader: RTL and testbench



---
 rtl/isa_pkg.sv | 38 +++
 rtl/imem_ram.sv | 29 ++
 rtl/imem_loader.sv | 108 ++++++++++
 tb/tb_imem_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction-memory loader: opcode encodings,
// word/address widths, loader state encoding and the opcode legality check.
package isa_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 8;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_INV  = 4'h5;
   localparam logic [3:0] OP_LOAD = 4'h8;
   localparam logic [3:0] OP_INC  = 4'hA;
   localparam logic [3:0] OP_DEC  = 4'hB;
   localparam logic [3:0] OP_HLT  = 4'hC;
   localparam logic [3:0] OP_JNZ  = 4'hE;
   localparam logic [3:0] OP_JMP  = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BASE,
      ST_COUNT,
      ST_HI,
      ST_LO,
      ST_FIN
   } loader_state_t;

   function automatic logic is_legal_opcode(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_INV,
         OP_LOAD, OP_INC, OP_DEC, OP_HLT, OP_JNZ, OP_JMP: return 1'b1;
         default:                                         return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction store: one write port, one registered read port. A read and a
// write to the same address in one cycle return the previous contents.
module imem_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Storage has no reset so a loaded program survives rst_n.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles 16-bit words and writes them into the
// instruction store, which also serves the fetch port.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | no session; waits for load_start
//   ST_BASE  | expecting base address byte
//   ST_COUNT | expecting word count byte (0 means full depth)
//   ST_HI    | expecting high byte of the next word
//   ST_LO    | expecting low byte; word is written on acceptance
//   ST_FIN   | one-cycle done pulse, then back to idle
module imem_loader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [7:0]        in_byte,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   output logic              err_opcode,
   output logic [8:0]        words_loaded,
   input  logic [ADDR_W-1:0] pc,
   input  logic              en,
   output logic [DATA_W-1:0] ir_data
);
   import isa_pkg::*;

   localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

   loader_state_t     state;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   words_left;
   logic [7:0]        hi_byte;

   logic              accept;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   assign in_ready = (state == ST_BASE) || (state == ST_COUNT) ||
                     (state == ST_HI)   || (state == ST_LO);
   assign busy     = (state != ST_IDLE);
   assign done     = (state == ST_FIN);

   // An abort in the same cycle drops the byte, so it also blocks the write.
   assign accept   = in_valid && in_ready && !abort;
   assign wr_en    = accept && (state == ST_LO);
   assign wr_addr  = base_addr + words_loaded[ADDR_W-1:0];
   assign wr_data  = {hi_byte, in_byte};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         base_addr    <= '0;
         words_left   <= '0;
         hi_byte      <= '0;
         err_opcode   <= 1'b0;
         words_loaded <= '0;
      end else if (abort && state != ST_IDLE) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (load_start) begin
               state        <= ST_BASE;
               err_opcode   <= 1'b0;
               words_loaded <= '0;
            end
            ST_BASE: if (accept) begin
               base_addr <= in_byte[ADDR_W-1:0];
               state     <= ST_COUNT;
            end
            ST_COUNT: if (accept) begin
               words_left <= (in_byte == 8'd0) ? DEPTH : (ADDR_W+1)'(in_byte);
               state      <= ST_HI;
            end
            ST_HI: if (accept) begin
               hi_byte <= in_byte;
               state   <= ST_LO;
            end
            ST_LO: if (accept) begin
               words_loaded <= words_loaded + 9'd1;
               words_left   <= words_left - (ADDR_W+1)'(1);
               if (!is_legal_opcode(hi_byte[7:4])) err_opcode <= 1'b1;
               state <= (words_left == (ADDR_W+1)'(1)) ? ST_FIN : ST_HI;
            end
            ST_FIN:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   imem_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (en),
      .rd_addr (pc),
      .rd_data (ir_data)
   );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load sessions, stalls, abort, mid-session
// reset, then a table of fetch vectors with hand-computed contents.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_start, abort, in_valid, en;
   logic [7:0]  in_byte, pc;
   logic        in_ready, busy, done, err_opcode;
   logic [8:0]  words_loaded;
   logic [15:0] ir_data;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;

   imem_loader #(.ADDR_W(8), .DATA_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_start   (load_start),
      .abort        (abort),
      .in_valid     (in_valid),
      .in_byte      (in_byte),
      .in_ready     (in_ready),
      .busy         (busy),
      .done         (done),
      .err_opcode   (err_opcode),
      .words_loaded (words_loaded),
      .pc           (pc),
      .en           (en),
      .ir_data      (ir_data)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_cnt++;

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] exp;
   } fvec_t;

   fvec_t fv[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stall);
      int n;
      if (stall) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 3)) tick();
      end
      in_valid = 1'b1;
      in_byte  = b;
      n = 0;
      while (!in_ready && n < 20) begin tick(); n++; end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL send_byte_timeout: in_ready stayed %b, required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      load_start = 1'b1; tick(); load_start = 1'b0;
   endtask

   task automatic run_load(input logic [7:0] base, input int n,
                           input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3,
                           input bit stall, input bit mid_start);
      logic [15:0] w [4];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      pulse_start();
      send_byte(base, stall);
      send_byte(8'(n), stall);
      for (int i = 0; i < n; i++) begin
         send_byte(w[i][15:8], stall);
         send_byte(w[i][7:0], stall);
         if (mid_start && i == 0) pulse_start();
      end
   endtask

   task automatic fetch(input logic [7:0] a, output logic [15:0] d);
      pc = a; en = 1'b1; tick(); en = 1'b0;
      d = ir_data;
   endtask

   initial begin
      logic [15:0] d;
      fv[0]  = '{8'h10, 16'h8105};
      fv[1]  = '{8'h11, 16'h0A12};
      fv[2]  = '{8'hFF, 16'hF000};
      fv[3]  = '{8'h00, 16'hC000};
      fv[4]  = '{8'h20, 16'h6123};
      fv[5]  = '{8'h40, 16'h1234};
      fv[6]  = '{8'h41, 16'hA0FF};
      fv[7]  = '{8'h42, 16'hE001};
      fv[8]  = '{8'h60, 16'h1111};
      fv[9]  = '{8'h61, 16'hA1A1};
      fv[10] = '{8'h62, 16'hA2A2};
      fv[11] = '{8'h63, 16'hA3A3};
      fv[12] = '{8'h70, 16'h7000};

      rst_n = 1'b0; load_start = 0; abort = 0; in_valid = 0; in_byte = 0; en = 0; pc = 0;
      tick(); tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ir_data", ir_data, 0);
      rst_n = 1'b1; tick();

      // Basic two-word load
      done_cnt = 0;
      run_load(8'h10, 2, 16'h8105, 16'h0A12, 0, 0, 0, 0);
      chk("t1_words_loaded_fin", words_loaded, 2);
      chk("t1_done_in_fin", done, 1);
      tick();
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_err", err_opcode, 0);
      chk("t1_busy_after", busy, 0);
      fetch(8'h11, d);
      chk("t1_fetch_11", d, 16'h0A12);

      // Address wrap
      run_load(8'hFF, 2, 16'hF000, 16'hC000, 0, 0, 0, 0);
      tick();

      // Illegal opcode, sticky until next load_start
      run_load(8'h20, 1, 16'h6123, 0, 0, 0, 0, 0);
      chk("t3_err_set", err_opcode, 1);
      tick();
      chk("t3_err_held_idle", err_opcode, 1);
      pulse_start();
      chk("t3_err_cleared", err_opcode, 0);
      chk("t3_words_cleared", words_loaded, 0);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("t3_abort_idle", busy, 0);

      // Stalled load with a mid-session load_start
      done_cnt = 0;
      run_load(8'h40, 3, 16'h1234, 16'hA0FF, 16'hE001, 0, 1, 1);
      chk("t4_words_loaded", words_loaded, 3);
      tick();
      chk("t4_done_cnt", done_cnt, 1);

      // Abort after the first word, with a valid byte in the abort cycle
      run_load(8'h60, 4, 16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3, 0, 0);
      tick();
      done_cnt = 0;
      pulse_start();
      send_byte(8'h60, 0);
      send_byte(8'h04, 0);
      send_byte(8'h11, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      chk("t5_in_lo_ready", in_ready, 1);
      in_valid = 1'b1; in_byte = 8'h22; abort = 1'b1;
      tick();
      in_valid = 1'b0; abort = 1'b0;
      chk("t5_abort_busy", busy, 0);
      chk("t5_words_loaded", words_loaded, 1);
      tick();
      chk("t5_no_done", done_cnt, 0);
      chk("t5_words_hold", words_loaded, 1);

      // Reset during HI
      fetch(8'h10, d);
      chk("t6_pre_fetch", d, 16'h8105);
      pulse_start();
      send_byte(8'h70, 0);
      send_byte(8'h02, 0);
      send_byte(8'h70, 0);
      send_byte(8'h00, 0);
      chk("t6_err_before_rst", err_opcode, 1);
      rst_n = 1'b0; tick();
      chk("t6_rst_in_ready", in_ready, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_done", done, 0);
      chk("t6_rst_err", err_opcode, 0);
      chk("t6_rst_words", words_loaded, 0);
      chk("t6_rst_ir_data", ir_data, 0);
      rst_n = 1'b1; tick();

      // Fetch table across all sessions
      for (int i = 0; i < 13; i++) begin
         fetch(fv[i].addr, d);
         chk($sformatf("fetch_%h", fv[i].addr), d, fv[i].exp);
      end

      // en=0 holds the last fetched word
      fetch(8'h10, d);
      pc = 8'h11; tick();
      chk("fetch_hold_en0", ir_data, 16'h8105);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: sim time exceeded");
      $fatal(1, "timeout");
   end

endmodule
